// File: rtl/obi_sram_arb_pkg.sv
// obi_sram_arb_pkg: shared OBI channel types, default widths and index helpers for the SRAM arbiter.
package obi_sram_arb_pkg;
    localparam int unsigned DefNumMgr    = 2;
    localparam int unsigned DefAddrWidth = 32;
    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefMaxTrans  = 2;

    typedef struct packed {
        logic [DefAddrWidth-1:0]   addr;
        logic                      we;
        logic [DefDataWidth/8-1:0] be;
        logic [DefDataWidth-1:0]   wdata;
    } obi_a_t;

    typedef struct packed {
        logic [DefDataWidth-1:0] rdata;
        logic                    err;
    } obi_r_t;

    // Pointer width that stays at least one bit for single-entry structures.
    function automatic int unsigned ptr_w(int unsigned n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/obi_sram_arbiter_if.sv
// obi_sram_arbiter_if: manager-side and subordinate-side OBI signals of the SRAM arbiter.
interface obi_sram_arbiter_if
    import obi_sram_arb_pkg::*;
#(
    parameter int unsigned NumMgr    = DefNumMgr,
    parameter int unsigned AddrWidth = DefAddrWidth,
    parameter int unsigned DataWidth = DefDataWidth
);
    localparam int unsigned BeWidth = DataWidth / 8;

    logic [NumMgr-1:0]                 mgr_req_i;
    logic [NumMgr-1:0]                 mgr_gnt_o;
    logic [NumMgr-1:0][AddrWidth-1:0]  mgr_addr_i;
    logic [NumMgr-1:0]                 mgr_we_i;
    logic [NumMgr-1:0][BeWidth-1:0]    mgr_be_i;
    logic [NumMgr-1:0][DataWidth-1:0]  mgr_wdata_i;
    logic [NumMgr-1:0]                 mgr_rvalid_o;
    logic [DataWidth-1:0]              mgr_rdata_o;
    logic [NumMgr-1:0]                 mgr_err_o;
    logic                              sbr_req_o;
    logic                              sbr_gnt_i;
    logic [AddrWidth-1:0]              sbr_addr_o;
    logic                              sbr_we_o;
    logic [BeWidth-1:0]                sbr_be_o;
    logic [DataWidth-1:0]              sbr_wdata_o;
    logic                              sbr_rvalid_i;
    logic [DataWidth-1:0]              sbr_rdata_i;
    logic                              sbr_err_i;

    modport slave (
        input  mgr_req_i, mgr_addr_i, mgr_we_i, mgr_be_i, mgr_wdata_i,
        input  sbr_gnt_i, sbr_rvalid_i, sbr_rdata_i, sbr_err_i,
        output mgr_gnt_o, mgr_rvalid_o, mgr_rdata_o, mgr_err_o,
        output sbr_req_o, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o
    );

    modport master (
        output mgr_req_i, mgr_addr_i, mgr_we_i, mgr_be_i, mgr_wdata_i,
        output sbr_gnt_i, sbr_rvalid_i, sbr_rdata_i, sbr_err_i,
        input  mgr_gnt_o, mgr_rvalid_o, mgr_rdata_o, mgr_err_o,
        input  sbr_req_o, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o
    );
endinterface

// File: rtl/obi_arb_rsp_fifo.sv
// obi_arb_rsp_fifo: in-order FIFO of granted manager indices used to route responses back.
module obi_arb_rsp_fifo
    import obi_sram_arb_pkg::*;
#(
    parameter int unsigned Depth = DefMaxTrans,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);
    localparam int unsigned PtrW = ptr_w(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_q, rd_q;
    logic [CntW-1:0]  cnt_q;

    assign full_o  = cnt_q == CntW'(Depth);
    assign empty_o = cnt_q == '0;
    assign head_o  = mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q == PtrW'(Depth - 1) ? '0 : wr_q + 1'b1;
            end
            if (pop_i) rd_q <= rd_q == PtrW'(Depth - 1) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CntW'(push_i) - CntW'(pop_i);
        end
    end
endmodule

// File: rtl/obi_sram_arbiter.sv
// obi_sram_arbiter: round-robin N-to-1 OBI arbiter in front of a zero-wait SRAM, in-order response routing.
// Optional conflict counter output conflict_cnt_o when OBI_SRAM_ARB_PERF_EN is defined.
module obi_sram_arbiter
    import obi_sram_arb_pkg::*;
#(
    parameter int unsigned NumMgr    = DefNumMgr,
    parameter int unsigned AddrWidth = DefAddrWidth,
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned MaxTrans  = DefMaxTrans
) (
    input  logic               clk_i,
    input  logic               rst_i,
    obi_sram_arbiter_if.slave  bus
`ifdef OBI_SRAM_ARB_PERF_EN
    ,
    output logic [31:0]        conflict_cnt_o
`endif
);
    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned IdxWidth = $clog2(NumMgr);

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 we;
        logic [BeWidth-1:0]   be;
        logic [DataWidth-1:0] wdata;
    } a_chan_t;

    logic [IdxWidth-1:0] rr_q, rr_d, win, idx, head;
    logic                full, empty, pop, accept, hs, rsp;
    a_chan_t             a_win;

    // Scan offsets downward so the smallest offset from rr_q is the last to win.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = NumMgr - 1; k >= 0; k--) begin
            idx = IdxWidth'((int'(rr_q) + k) % NumMgr);
            win = bus.mgr_req_i[idx] ? idx : win;
        end
    end

    assign pop    = bus.sbr_rvalid_i && !empty;
    assign accept = !full || pop;
    assign hs     = bus.sbr_req_o && bus.sbr_gnt_i;
    assign rsp    = pop && !rst_i;
    assign rr_d   = hs ? (win == IdxWidth'(NumMgr - 1) ? '0 : win + 1'b1) : rr_q;

    assign a_win = '{addr: bus.mgr_addr_i[win], we: bus.mgr_we_i[win],
                     be: bus.mgr_be_i[win], wdata: bus.mgr_wdata_i[win]};

    assign bus.sbr_req_o    = !rst_i && |bus.mgr_req_i && accept;
    assign bus.sbr_addr_o   = a_win.addr;
    assign bus.sbr_we_o     = a_win.we;
    assign bus.sbr_be_o     = a_win.be;
    assign bus.sbr_wdata_o  = a_win.wdata;
    assign bus.mgr_gnt_o    = hs ? NumMgr'(1) << win : '0;
    assign bus.mgr_rvalid_o = rsp ? NumMgr'(1) << head : '0;
    assign bus.mgr_err_o    = rsp && bus.sbr_err_i ? NumMgr'(1) << head : '0;
    assign bus.mgr_rdata_o  = bus.sbr_rdata_i;

    always_ff @(posedge clk_i) begin
        rr_q <= rst_i ? '0 : rr_d;
    end

    obi_arb_rsp_fifo #(
        .Depth (MaxTrans),
        .Width (IdxWidth)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (hs),
        .data_i  (win),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

`ifdef OBI_SRAM_ARB_PERF_EN
    logic [31:0] conflict_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) conflict_q <= '0;
        else if (hs && $countones(bus.mgr_req_i) >= 2 && conflict_q != '1) conflict_q <= conflict_q + 1'b1;
    end

    assign conflict_cnt_o = conflict_q;
`endif

`ifndef SYNTHESIS
    // The cycle after reset release may legally carry a response to a discarded transaction.
    logic rst_q;

    always_ff @(posedge clk_i) begin
        rst_q <= rst_i;
        if (!rst_i && !rst_q) assert (!(bus.sbr_rvalid_i && empty)) else $error("obi_sram_arbiter: rvalid with no outstanding transaction");
    end
`endif
endmodule

// File: doc/obi_sram_arbiter.md
Name: obi_sram_arbiter

Overview:
- N-manager to 1-subordinate OBI arbiter that shares one zero-wait SRAM bank (gnt = req, rvalid one cycle later) between the core instruction port, data port and debug/DMA masters.
- Round-robin request arbitration on the A-channel.
- Routes R-channel responses back to the issuing manager through an in-order transaction-ID FIFO.
- Sits directly in front of the SRAM OBI subordinate in the zeroHETI memory subsystem.

Parameters:
- NumMgr, 2, number of manager ports (≥2).
- AddrWidth, 32, OBI address width.
- DataWidth, 32, OBI data width; BeWidth = DataWidth/8 (localparam).
- MaxTrans, 2, depth of the response-routing FIFO (≥1); maximum outstanding transactions.
- IdxWidth, $clog2(NumMgr) (localparam), manager index width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- mgr_req_i  in  NumMgr  per-manager request
- mgr_gnt_o  out  NumMgr  per-manager grant
- mgr_addr_i  in  NumMgr×AddrWidth  addresses
- mgr_we_i  in  NumMgr  write enables
- mgr_be_i  in  NumMgr×BeWidth  byte enables
- mgr_wdata_i  in  NumMgr×DataWidth  write data
- mgr_rvalid_o  out  NumMgr  per-manager response valid
- mgr_rdata_o  out  DataWidth  read data, broadcast to all managers
- mgr_err_o  out  NumMgr  per-manager error
- sbr_req_o  out  1  subordinate request
- sbr_gnt_i  in  1  subordinate grant
- sbr_addr_o  out  AddrWidth  muxed address
- sbr_we_o  out  1  muxed write enable
- sbr_be_o  out  BeWidth  muxed byte enables
- sbr_wdata_o  out  DataWidth  muxed write data
- sbr_rvalid_i  in  1  subordinate response valid
- sbr_rdata_i  in  DataWidth  subordinate read data
- sbr_err_i  in  1  subordinate error

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_i is synchronous and active-high.
- Reset state:
  - rr_ptr = 0.
  - FIFO empty (wr_ptr = rd_ptr = 0, count = 0).
  - mgr_rvalid_o = 0 and mgr_err_o = 0 from the first cycle after reset.
  - mgr_gnt_o and sbr_req_o are combinational from the inputs, but forced 0 while rst_i = 1.
- Accept condition:
  - accept = !full || pop, where pop = sbr_rvalid_i && !empty.
  - This is a combinational full-bypass path.
- Arbitration (combinational):
  - Winner = first requesting index at or after rr_ptr, searching upward with modular wrap.
  - sbr_req_o = |mgr_req_i && accept.
  - sbr_addr/we/be/wdata are muxed from the winner. When no manager requests, they are driven from index 0 (don't-care).
  - mgr_gnt_o[winner] = sbr_gnt_i && sbr_req_o. All other grants are 0.
- Handshake (hs = sbr_req_o && sbr_gnt_i):
  - Push the winner index into the FIFO.
  - rr_ptr <= (winner+1) mod NumMgr.
  - With no handshake, rr_ptr holds.
- Response:
  - When sbr_rvalid_i && !empty: mgr_rvalid_o[fifo_head] = 1, mgr_err_o[fifo_head] = sbr_err_i, then pop.
  - mgr_rdata_o = sbr_rdata_i, unqualified.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal when full (bypass) and when empty-then-push. A push into an empty FIFO is not visible to a same-cycle rvalid.
- Full without pop: sbr_req_o = 0 and no grants. Requests stay pending and OBI-stable.
- sbr_rvalid_i while empty: ignored, with no manager rvalid. A simulation assertion fires.
- Pointers wrap modulo MaxTrans. Count width is $clog2(MaxTrans+1).
- Throughput: with the zero-wait SRAM, one transaction per cycle is sustained for MaxTrans ≥ 1. Fairness bound: a continuously requesting manager waits at most NumMgr−1 grants.
- Reset mid-operation: outstanding entries are discarded. Any sbr_rvalid_i in the cycle after reset release is ignored, because the FIFO is empty.

Optional Feature:
- Macro: OBI_SRAM_ARB_PERF_EN.
- When defined:
  - Adds output port conflict_cnt_o (32 bits).
  - The counter increments, saturating at 32'hFFFF_FFFF, in every cycle where popcount(mgr_req_i) ≥ 2 and hs = 1.
  - Resets to 0 on rst_i.
- When undefined: the port and counter do not exist, and behaviour is otherwise identical.

Decomposition:
- Package obi_sram_arb_pkg contains:
  - typedef obi_a_t: addr, we, be, wdata.
  - typedef obi_r_t: rdata, err.
  - Default width constants.
- One natural sub-module: obi_arb_rsp_fifo. It holds the index FIFO (push, pop, full, empty, head) and contains no bypass logic; the bypass stays in the top.

Test Plan:
- Single manager 0: repeated reads of address 0x10 with SRAM word 0xDEADBEEF → gnt in the same cycle, mgr_rvalid_o = 2'b01 one cycle later, rdata 0xDEADBEEF. Manager 1 sees no rvalid.
- Both managers requesting continuously for 6 cycles → grants alternate 0,1,0,1,0,1. Each rvalid returns to the correct index one cycle after its grant.
- Manager 1 writes 0xCAFE0000 to 0x20 in the same cycle manager 0 reads 0x20 (rr_ptr = 1) → manager 1 is granted first, and manager 0's later read returns 0xCAFE0000.
- Subordinate gnt held low for 3 cycles, MaxTrans = 1 → sbr_req_o stays 1 and mgr_gnt_o stays 0. Grants proceed once gnt rises. The FIFO never exceeds 1 entry.
- rst_i asserted with 1 entry outstanding, then an rvalid pulse in the next cycle → no mgr_rvalid_o, and rr_ptr returns to 0.
- OBI_SRAM_ARB_PERF_EN defined, both managers requesting for 5 granted cycles → conflict_cnt_o = 5. A single requester adds 0.
